// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB register-bank completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } apb_cmp_state_t;

   localparam logic [7:0]  APB_ID_ADDR     = 8'hFE;
   localparam logic [7:0]  APB_ERRCNT_ADDR = 8'hFF;
   localparam logic [31:0] APB_ID_VALUE    = 32'hA9B0_0001;

endpackage

// File: rtl/apb_regbank.sv
// DEPTH x DATA_W register storage: one synchronous write port, one
// combinational read port, asynchronously cleared on reset.
module apb_regbank #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32
) (
   input  logic                     apb_clk,
   input  logic                     apb_reset_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array: cleared on reset, written one entry per edge
   always_ff @(posedge apb_clk or negedge apb_reset_n) begin
      if (!apb_reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/apb_regbank_completer.sv
// APB completer in front of a register bank: setup/access decode, programmable
// wait states, registered response, read-only ID word and saturating error counter.
module apb_regbank_completer
   import apb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned WAIT_W = 4
) (
   input  logic              apb_clk,
   input  logic              apb_reset_n,
   input  logic              apb_selx,
   input  logic              apb_en,
   input  logic              apb_write,
   input  logic [ADDR_W-1:0] apb_addr,
   input  logic [DATA_W-1:0] apb_wdata,
   output logic [DATA_W-1:0] apb_rdata,
   output logic              apb_ready,
   output logic              apb_slverr,
   input  logic [WAIT_W-1:0] wait_cycle,
   output logic [7:0]        err_count
);

   localparam int unsigned       IDX_W       = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] BANK_END    = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ID_ADDR     = ADDR_W'(APB_ID_ADDR);
   localparam logic [ADDR_W-1:0] ERRCNT_ADDR = ADDR_W'(APB_ERRCNT_ADDR);

   apb_cmp_state_t    state, state_nxt;
   logic [WAIT_W-1:0] cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;

   logic              setup;
   logic [ADDR_W-1:0] dec_addr;
   logic              dec_write;
   logic              in_bank;
   logic              dec_err;
   logic [DATA_W-1:0] dec_rdata;
   logic [DATA_W-1:0] bank_rdata;

   logic              load_resp;
   logic              bank_we;
   logic              err_inc;
   logic              err_clr;

   assign setup = apb_selx & ~apb_en;

   // In IDLE the decode looks at the live bus (zero-wait responses), later at the latched transfer
   assign dec_addr  = (state == IDLE) ? apb_addr  : addr_q;
   assign dec_write = (state == IDLE) ? apb_write : write_q;
   assign in_bank   = dec_addr < BANK_END;

   apb_regbank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_bank (
      .apb_clk     (apb_clk),
      .apb_reset_n (apb_reset_n),
      .wr_en       (bank_we),
      .wr_addr     (addr_q[IDX_W-1:0]),
      .wr_data     (wdata_q),
      .rd_addr     (dec_addr[IDX_W-1:0]),
      .rd_data     (bank_rdata)
   );

   // Address decode: error flag and the read value the response would carry
   always_comb begin
      if (dec_write) begin
         dec_err = !(in_bank || dec_addr == ERRCNT_ADDR);
      end else begin
         dec_err = !(in_bank || dec_addr == ID_ADDR || dec_addr == ERRCNT_ADDR);
      end
      dec_rdata = '0;
      if (!dec_err && !dec_write) begin
         if (in_bank) begin
            dec_rdata = bank_rdata;
         end else if (dec_addr == ID_ADDR) begin
            dec_rdata = DATA_W'(APB_ID_VALUE);
         end else begin
            dec_rdata = DATA_W'(err_count);
         end
      end
   end

   // State register
   always_ff @(posedge apb_clk or negedge apb_reset_n) begin
      if (!apb_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (setup) begin
               state_nxt = (wait_cycle == '0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!apb_selx) begin
               state_nxt = IDLE;
            end else if (cnt == WAIT_W'(1)) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: response load, bank commit and error-counter controls
   always_comb begin
      load_resp = 1'b0;
      bank_we   = 1'b0;
      err_inc   = 1'b0;
      err_clr   = 1'b0;
      unique case (state)
         IDLE: begin
            load_resp = setup && (wait_cycle == '0);
            err_inc   = apb_selx && apb_en;
         end
         WAIT: begin
            load_resp = apb_selx && (cnt == WAIT_W'(1));
         end
         RESP: begin
            bank_we = apb_selx && apb_en && write_q && !apb_slverr && in_bank;
            err_clr = apb_selx && apb_en && write_q && !apb_slverr && (addr_q == ERRCNT_ADDR);
            err_inc = apb_slverr;
         end
         default: ;
      endcase
   end

   // Transfer latch, wait counter and registered response
   always_ff @(posedge apb_clk or negedge apb_reset_n) begin
      if (!apb_reset_n) begin
         cnt        <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         apb_ready  <= 1'b0;
         apb_slverr <= 1'b0;
         apb_rdata  <= '0;
      end else begin
         if (state == IDLE && setup) begin
            addr_q  <= apb_addr;
            write_q <= apb_write;
            wdata_q <= apb_wdata;
            cnt     <= wait_cycle;
         end else if (state == WAIT && apb_selx) begin
            cnt <= cnt - WAIT_W'(1);
         end
         apb_ready  <= load_resp;
         apb_slverr <= load_resp && dec_err;
         apb_rdata  <= load_resp ? dec_rdata : '0;
      end
   end

   // Saturating error counter; a clear takes priority over an increment
   always_ff @(posedge apb_clk or negedge apb_reset_n) begin
      if (!apb_reset_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (err_inc && err_count != 8'hFF) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_apb_regbank_completer.sv
// Self-checking bench for apb_regbank_completer: directed vector table,
// hand-written corner sequences and random transfers against a reference model.
module tb_apb_regbank_completer;

   logic        apb_clk     = 1'b0;
   logic        apb_reset_n = 1'b0;
   logic        apb_selx    = 1'b0;
   logic        apb_en      = 1'b0;
   logic        apb_write   = 1'b0;
   logic [7:0]  apb_addr    = '0;
   logic [31:0] apb_wdata   = '0;
   logic [31:0] apb_rdata;
   logic        apb_ready;
   logic        apb_slverr;
   logic [3:0]  wait_cycle  = '0;
   logic [7:0]  err_count;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [31:0] m_mem [32];
   int          m_err;

   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [31:0] d;
      int          wc;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        b2b;
   } vec_t;

   vec_t tbl [$];

   apb_regbank_completer #(
      .DATA_W (32),
      .ADDR_W (8),
      .DEPTH  (32),
      .WAIT_W (4)
   ) dut (
      .apb_clk     (apb_clk),
      .apb_reset_n (apb_reset_n),
      .apb_selx    (apb_selx),
      .apb_en      (apb_en),
      .apb_write   (apb_write),
      .apb_addr    (apb_addr),
      .apb_wdata   (apb_wdata),
      .apb_rdata   (apb_rdata),
      .apb_ready   (apb_ready),
      .apb_slverr  (apb_slverr),
      .wait_cycle  (wait_cycle),
      .err_count   (err_count)
   );

   always #5 apb_clk = ~apb_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void add(input logic w, input logic [7:0] a, input logic [31:0] d,
                               input int wc, input logic [31:0] exp_rd, input logic exp_err,
                               input logic b2b);
      vec_t v;
      v.w = w; v.a = a; v.d = d; v.wc = wc;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.b2b = b2b;
      tbl.push_back(v);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_err = 0;
   endfunction

   // address-map rules applied to one completed transfer
   function automatic void model_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                                      output logic [31:0] rd, output logic err);
      bit bank;
      bank = (a < 8'd32);
      if (w) err = !(bank || a == 8'hFF);
      else   err = !(bank || a == 8'hFE || a == 8'hFF);
      rd = '0;
      if (err) begin
         if (m_err < 255) m_err++;
      end else if (w) begin
         if (bank) m_mem[a[4:0]] = d;
         else      m_err = 0;
      end else begin
         if (bank)            rd = m_mem[a[4:0]];
         else if (a == 8'hFE) rd = 32'hA9B0_0001;
         else                 rd = 32'(m_err);
      end
   endfunction

   // one transfer; returns after the cycle in which ready was seen, selx/en still high
   task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input int wc,
                       output logic [31:0] rd, output logic se, output int lat);
      @(posedge apb_clk); #1;
      chk("setup_ready_low", apb_ready, 0);
      chk("err_count", err_count, 32'(m_err));
      apb_selx   = 1'b1;
      apb_en     = 1'b0;
      apb_write  = w;
      apb_addr   = a;
      apb_wdata  = d;
      wait_cycle = 4'(wc);
      @(posedge apb_clk); #1;
      apb_en = 1'b1;
      lat = 0;
      while (apb_ready !== 1'b1 && lat < 40) begin
         @(posedge apb_clk); #1;
         lat++;
      end
      if (lat >= 40) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout addr=0x%02h no ready within 40 cycles", a);
      end
      rd = apb_rdata;
      se = apb_slverr;
   endtask

   // close the access at the next edge and return the bus to idle
   task automatic idle();
      @(posedge apb_clk); #1;
      chk("ready_one_cycle", apb_ready, 0);
      apb_selx = 1'b0;
      apb_en   = 1'b0;
   endtask

   task automatic run(input logic w, input logic [7:0] a, input logic [31:0] d, input int wc,
                      input string tag, output logic [31:0] rd, output logic se);
      logic [31:0] mrd;
      logic        merr;
      int          lat;
      xfer(w, a, d, wc, rd, se, lat);
      model_xfer(w, a, d, mrd, merr);
      chk({tag, "_latency"}, 32'(lat), 32'(wc));
      chk({tag, "_rdata"}, rd, mrd);
      chk({tag, "_slverr"}, 32'(se), 32'(merr));
   endtask

   task automatic viol_once();
      @(posedge apb_clk); #1;
      apb_selx = 1'b1;
      apb_en   = 1'b1;
      apb_addr = 8'($urandom);
      @(posedge apb_clk); #1;
      if (m_err < 255) m_err++;
      chk("viol_err_count", err_count, 32'(m_err));
      chk("viol_ready", apb_ready, 0);
      apb_selx = 1'b0;
      apb_en   = 1'b0;
      @(posedge apb_clk); #1;
      chk("viol_no_resp", apb_ready, 0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        se;
      bit          seen;

      model_reset();

      // reset state
      repeat (3) @(posedge apb_clk);
      #1;
      chk("rst_ready", apb_ready, 0);
      chk("rst_slverr", apb_slverr, 0);
      chk("rst_rdata", apb_rdata, 0);
      chk("rst_err_count", err_count, 0);
      apb_reset_n = 1'b1;

      // directed vectors
      add(1'b1, 8'd4,   32'h0000_000A, 0,  32'h0,          1'b0, 1'b1);
      add(1'b0, 8'd4,   32'h0,         0,  32'h0000_000A,  1'b0, 1'b0);
      add(1'b1, 8'd5,   32'h0000_000C, 3,  32'h0,          1'b0, 1'b1);
      add(1'b0, 8'd5,   32'h0,         3,  32'h0000_000C,  1'b0, 1'b0);
      add(1'b0, 8'd100, 32'h0,         1,  32'h0,          1'b1, 1'b1);
      add(1'b1, 8'd100, 32'hDEAD_BEEF, 2,  32'h0,          1'b1, 1'b0);
      add(1'b0, 8'hFF,  32'h0,         0,  32'h2,          1'b0, 1'b0);
      add(1'b1, 8'hFF,  32'h0,         1,  32'h0,          1'b0, 1'b1);
      add(1'b0, 8'hFF,  32'h0,         0,  32'h0,          1'b0, 1'b0);
      add(1'b1, 8'hFE,  32'h1234_5678, 0,  32'h0,          1'b1, 1'b1);
      add(1'b0, 8'hFE,  32'h0,         2,  32'hA9B0_0001,  1'b0, 1'b0);
      add(1'b0, 8'hFF,  32'h0,         0,  32'h1,          1'b0, 1'b0);
      add(1'b0, 8'd31,  32'h0,         15, 32'h0,          1'b0, 1'b0);
      add(1'b1, 8'd31,  32'hFFFF_FFFF, 0,  32'h0,          1'b0, 1'b1);
      add(1'b0, 8'd31,  32'h0,         1,  32'hFFFF_FFFF,  1'b0, 1'b0);
      add(1'b0, 8'd32,  32'h0,         0,  32'h0,          1'b1, 1'b1);
      add(1'b1, 8'd32,  32'h0000_0005, 0,  32'h0,          1'b1, 1'b0);
      add(1'b0, 8'hFF,  32'h0,         0,  32'h3,          1'b0, 1'b0);
      add(1'b0, 8'd4,   32'h0,         0,  32'h0000_000A,  1'b0, 1'b1);
      add(1'b0, 8'd5,   32'h0,         2,  32'h0000_000C,  1'b0, 1'b0);

      foreach (tbl[i]) begin
         run(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].wc, $sformatf("tbl%0d", i), rd, se);
         chk($sformatf("tbl%0d_rdata_const", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_slverr_const", i), 32'(se), 32'(tbl[i].exp_err));
         if (!tbl[i].b2b) idle();
      end
      if (tbl[tbl.size()-1].b2b) idle();

      // abort: selx dropped during WAIT of a write to addr 3
      @(posedge apb_clk); #1;
      apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1;
      apb_addr = 8'd3; apb_wdata = 32'h0000_0055; wait_cycle = 4'd4;
      @(posedge apb_clk); #1;
      apb_en = 1'b1;
      @(posedge apb_clk); #1;
      apb_selx = 1'b0; apb_en = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge apb_clk); #1;
         if (apb_ready === 1'b1) seen = 1'b1;
      end
      chk("abort_no_ready", 32'(seen), 0);
      run(1'b0, 8'd3, 32'h0, 0, "abort_rd3", rd, se);
      chk("abort_addr3_const", rd, 32'h0);
      idle();

      // protocol violation from IDLE
      viol_once();
      viol_once();

      // saturation at 255, then clear by write
      @(posedge apb_clk); #1;
      apb_selx = 1'b1; apb_en = 1'b1;
      repeat (260) @(posedge apb_clk);
      #1;
      apb_selx = 1'b0; apb_en = 1'b0;
      m_err = 255;
      chk("err_count_saturated", err_count, 32'd255);
      run(1'b1, 8'hFF, 32'hFFFF_FFFF, 1, "errcnt_clear", rd, se);
      run(1'b0, 8'hFF, 32'h0, 0, "errcnt_read", rd, se);
      chk("errcnt_cleared_const", rd, 32'h0);
      idle();

      // asynchronous reset while in WAIT
      run(1'b1, 8'd4, 32'h0000_000A, 0, "pre_rst_wr", rd, se);
      idle();
      viol_once();
      @(posedge apb_clk); #1;
      apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b0;
      apb_addr = 8'd4; wait_cycle = 4'd6;
      @(posedge apb_clk); #1;
      apb_en = 1'b1;
      @(posedge apb_clk); #3;
      apb_reset_n = 1'b0;
      #1;
      chk("midrst_ready", apb_ready, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_slverr", apb_slverr, 0);
      apb_selx = 1'b0; apb_en = 1'b0; wait_cycle = 4'd0;
      @(posedge apb_clk); #1;
      apb_reset_n = 1'b1;
      model_reset();
      run(1'b0, 8'd4, 32'h0, 0, "post_rst_rd4", rd, se);
      chk("post_rst_addr4_const", rd, 32'h0);
      idle();

      // random transfers against the model
      for (int n = 0; n < 200; n++) begin
         logic [7:0] a;
         int         sel;
         int         wc;
         sel = int'($urandom_range(0, 9));
         if (sel <= 5)      a = 8'($urandom_range(0, 31));
         else if (sel == 6) a = 8'($urandom_range(32, 40));
         else if (sel == 7) a = 8'hFE;
         else if (sel == 8) a = 8'hFF;
         else               a = 8'($urandom_range(0, 255));
         wc = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
         run(1'($urandom_range(0, 1)), a, $urandom, wc, $sformatf("rnd%0d", n), rd, se);
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
